// File: rtl/msm_pkg.sv
// Shared types and defaults for the MSM bucket stage.
//   DEFAULT_COORD_W     : width of one affine coordinate
//   DEFAULT_WINDOW_BITS : signed-window digit width
//   point_t             : affine point {x, y}, x in the upper half when packed
//   bucket_idx_t        : bucket number / digit
//   acc_state_e         : bucket_accumulator FSM states
package msm_pkg;

  localparam int unsigned DEFAULT_COORD_W     = 256;
  localparam int unsigned DEFAULT_WINDOW_BITS = 4;

  typedef struct packed {
    logic [DEFAULT_COORD_W-1:0] x;
    logic [DEFAULT_COORD_W-1:0] y;
  } point_t;

  typedef logic [DEFAULT_WINDOW_BITS-1:0] bucket_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ISSUE,
    WAIT,
    FLUSH_OUT
  } acc_state_e;

endpackage

// File: rtl/bucket_regfile.sv
// Bucket storage: entries 1..2^AW-1, one async read port, one write port
// (write also sets the entry's valid bit) and a per-entry valid clear.
// Only the valid bits are reset; data of an invalid entry is don't-care.
//   clk, rst_n     : clock, synchronous active-low reset of valid bits
//   we/waddr/wdata : write port
//   clr/caddr      : clear valid bit of one entry
//   raddr/rdata/rvalid : read port
module bucket_regfile #(
  parameter int unsigned DW = 512,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          clr,
  input  logic [AW-1:0] caddr,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  localparam int unsigned NB = (1 << AW) - 1;

  // Entry 0 exists only to keep indexing direct; its valid bit is tied low.
  logic [DW-1:0] data_q [0:NB];
  logic [DW-1:0] data_d [0:NB];
  logic [NB:0]   valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) valid_d[caddr] = 1'b0;
    if (we) begin
      data_d[waddr]  = wdata;
      valid_d[waddr] = 1'b1;
    end
    valid_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  assign rdata  = data_q[raddr];
  assign rvalid = valid_q[raddr];

endmodule

// File: rtl/bucket_accumulator.sv
// MSM bucket accumulation stage feeding point_add.
// Points tagged with a window digit are accumulated into bucket[digit]
// (digit 0 dropped); an empty bucket is written directly, otherwise
// P=bucket, Q=point is sent to point_add and R written back. A flush
// drains buckets 1..NB in order, clearing each as it is accepted.
// Ports:
//   clk, Reset (sync, active-low)
//   in_valid/in_ready/in_point/in_digit : input stream, point = {x,y}
//   flush                               : level drain request
//   add_P/add_Q/add_reset/add_R/add_Done: point_add interface
//   out_valid/out_ready/out_point/out_index/out_empty/out_last : readout
//   busy                                : FSM not idle
// Optional macro BUCKET_COLLISION_DETECT_EN adds collision_err (sticky)
// and collision_cnt (saturating); an equal-x add is dropped and the bucket
// cleared instead of being sent to point_add.
module bucket_accumulator
  import msm_pkg::*;
#(
  parameter int unsigned COORD_W     = DEFAULT_COORD_W,
  parameter int unsigned WINDOW_BITS = DEFAULT_WINDOW_BITS
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*COORD_W-1:0]   in_point,
  input  logic [WINDOW_BITS-1:0] in_digit,
  input  logic                   flush,
  output logic [2*COORD_W-1:0]   add_P,
  output logic [2*COORD_W-1:0]   add_Q,
  output logic                   add_reset,
  input  logic [2*COORD_W-1:0]   add_R,
  input  logic                   add_Done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*COORD_W-1:0]   out_point,
  output logic [WINDOW_BITS-1:0] out_index,
  output logic                   out_empty,
  output logic                   out_last,
`ifdef BUCKET_COLLISION_DETECT_EN
  output logic                   collision_err,
  output logic [15:0]            collision_cnt,
`endif
  output logic                   busy
);

  localparam int unsigned DW = 2 * COORD_W;
  localparam logic [WINDOW_BITS-1:0] LAST_IDX = '1;

  acc_state_e             state_q, state_d;
  logic [DW-1:0]          pt_q, pt_d;
  logic [WINDOW_BITS-1:0] dig_q, dig_d;
  logic [WINDOW_BITS-1:0] ptr_q, ptr_d;
  logic                   first_q, first_d;

  logic                   rf_we, rf_clr, rd_valid;
  logic [WINDOW_BITS-1:0] rf_waddr, rf_caddr, rd_addr;
  logic [DW-1:0]          rf_wdata, rd_point;
  logic                   coll_hit;

`ifdef BUCKET_COLLISION_DETECT_EN
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  assign coll_hit = rd_valid && (rd_point[DW-1:COORD_W] == in_point[DW-1:COORD_W]);
  assign collision_err = err_q;
  assign collision_cnt = cnt_q;
`else
  assign coll_hit = 1'b0;
`endif

  bucket_regfile #(.DW(DW), .AW(WINDOW_BITS)) u_regfile (
    .clk    (clk),
    .rst_n  (Reset),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .clr    (rf_clr),
    .caddr  (rf_caddr),
    .raddr  (rd_addr),
    .rdata  (rd_point),
    .rvalid (rd_valid)
  );

  // The single read port follows the state: the incoming digit while idle
  // (to pick WRITE vs ISSUE), the latched digit during an add, the drain
  // pointer while flushing.
  always_comb begin
    case (state_q)
      IDLE:      rd_addr = in_digit;
      FLUSH_OUT: rd_addr = ptr_q;
      default:   rd_addr = dig_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pt_d     = pt_q;
    dig_d    = dig_q;
    ptr_d    = ptr_q;
    first_d  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = dig_q;
    rf_wdata = pt_q;
    rf_clr   = 1'b0;
    rf_caddr = ptr_q;
`ifdef BUCKET_COLLISION_DETECT_EN
    err_d = err_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (flush) begin
          ptr_d   = {{(WINDOW_BITS-1){1'b0}}, 1'b1};
          state_d = FLUSH_OUT;
        end else if (in_valid) begin
          pt_d  = in_point;
          dig_d = in_digit;
          if (in_digit != '0) begin
            if (!rd_valid) begin
              state_d = WRITE;
            end else if (coll_hit) begin
              rf_clr   = 1'b1;
              rf_caddr = in_digit;
`ifdef BUCKET_COLLISION_DETECT_EN
              err_d = 1'b1;
              if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
`endif
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      WRITE: begin
        rf_we   = 1'b1;
        state_d = IDLE;
      end
      ISSUE: begin
        first_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A Done seen on the first WAIT cycle may be stale from the
        // previous operation and is ignored.
        if (!first_q && add_Done) begin
          rf_we    = 1'b1;
          rf_wdata = add_R;
          state_d  = IDLE;
        end
      end
      FLUSH_OUT: begin
        if (out_ready) begin
          rf_clr = 1'b1;
          if (ptr_q == LAST_IDX) state_d = IDLE;
          else                   ptr_d   = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pt_q    <= '0;
      dig_q   <= '0;
      ptr_q   <= '0;
      first_q <= 1'b0;
`ifdef BUCKET_COLLISION_DETECT_EN
      err_q <= 1'b0;
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      dig_q   <= dig_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
`ifdef BUCKET_COLLISION_DETECT_EN
      err_q <= err_d;
      cnt_q <= cnt_d;
`endif
    end
  end

  // Outputs are forced to their reset values while Reset is low so an
  // in-flight add is held off immediately, not one edge later.
  logic in_add;
  assign in_add    = Reset && (state_q == ISSUE || state_q == WAIT);
  assign in_ready  = Reset && (state_q == IDLE) && !flush;
  assign busy      = Reset && (state_q != IDLE);
  assign add_reset = !(Reset && state_q == WAIT);
  assign add_P     = in_add ? rd_point : '0;
  assign add_Q     = in_add ? pt_q : '0;
  assign out_valid = Reset && (state_q == FLUSH_OUT);
  assign out_index = ptr_q;
  assign out_point = (out_valid && rd_valid) ? rd_point : '0;
  assign out_empty = out_valid && !rd_valid;
  assign out_last  = out_valid && (ptr_q == LAST_IDX);

endmodule

// File: doc/bucket_accumulator.md
Name: bucket_accumulator

Overview:
- MSM bucket stage that sits directly upstream of point_add.
- Accepts a stream of affine points, each tagged with a signed-window digit. It accumulates each point into the bucket selected by its digit by issuing P=bucket, Q=point to point_add and writing R back.
- On flush it streams every bucket out, in order, to the downstream bucket-reduction stage.
- One add is in flight at a time.

Parameters:
- COORD_W, 256, width of one affine coordinate (x or y).
- WINDOW_BITS, 4, digit width. Buckets are indexed 1..2^WINDOW_BITS-1; digit 0 is a no-op.

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset (Reset==0 resets on the clk edge).
- in_valid  in  1  input point/digit valid.
- in_ready  out  1  block can accept an input.
- in_point  in  2*COORD_W  {x,y}, with x in the upper half.
- in_digit  in  WINDOW_BITS  bucket select.
- flush  in  1  level request to drain all buckets.
- add_P  out  2*COORD_W  to point_add P.
- add_Q  out  2*COORD_W  to point_add Q.
- add_reset  out  1  active-high start/hold to point_add Reset.
- add_R  in  2*COORD_W  from point_add R.
- add_Done  in  1  from point_add Done.
- out_valid  out  1  bucket readout valid.
- out_ready  in  1  downstream accepts the readout.
- out_point  out  2*COORD_W  bucket contents.
- out_index  out  WINDOW_BITS  bucket number.
- out_empty  out  1  bucket has never been written (point at infinity).
- out_last  out  1  highest bucket.
- busy  out  1  state != IDLE.

Behaviour:
- Storage:
  - Register array bucket[1..NB], NB = 2^WINDOW_BITS-1.
  - Each entry holds a point plus a valid bit; valid=0 means infinity.
- Reset (Reset==0):
  - State goes to IDLE and all bucket valid bits clear.
  - in_ready=0, out_valid=0, add_reset=1, busy=0, add_P/add_Q=0.
  - Reset in any state aborts the operation; a point_add in flight is discarded because add_reset is held high.
- FSM states: IDLE, WRITE, ISSUE, WAIT, FLUSH_OUT.
- IDLE:
  - in_ready=1 iff flush==0. flush has priority over in_valid.
  - Accept on in_valid&&in_ready, latching in_point and in_digit.
  - Digit 0: drop the point and stay in IDLE, so in_ready is high again the next cycle.
  - Target bucket invalid: go to WRITE.
  - Target bucket valid: go to ISSUE.
  - flush==1: set ptr=1 and go to FLUSH_OUT.
- WRITE (1 cycle): bucket[d] <= latched point, valid<=1, then IDLE. Total accept-to-ready is 2 cycles.
- ISSUE (1 cycle): add_P=bucket[d], add_Q=latched point, add_reset=1, then WAIT.
- add_P/add_Q stability: held stable from ISSUE through the end of WAIT. add_reset=0 in WAIT.
- WAIT:
  - Ignore add_Done in the first WAIT cycle.
  - On the first later cycle with add_Done=1, set bucket[d] <= add_R, assert add_reset=1 the next cycle, and go to IDLE.
  - No timeout.
- add_reset is 1 in every state except WAIT.
- FLUSH_OUT:
  - out_valid=1, out_index=ptr, out_point=bucket[ptr] (0 when empty), out_empty=!valid[ptr], out_last=(ptr==NB).
  - On out_valid&&out_ready: clear valid[ptr]. If ptr==NB go to IDLE, else ptr++.
  - Outputs hold while out_ready=0.
  - flush deassertion mid-drain is ignored; the drain always completes.
- Hazards:
  - The same bucket on back-to-back inputs is safe, because input is blocked until write-back.
  - in_ready=0 throughout WRITE, ISSUE, WAIT and FLUSH_OUT.
- Widths: all datapath is pass-through with no arithmetic; ptr is WINDOW_BITS wide.

Optional Feature:
- Macro BUCKET_COLLISION_DETECT_EN.
- When defined:
  - Before ISSUE, compare the x-coordinate of bucket[d] against the incoming x.
  - If they are equal (doubling or inverse, which point_add cannot handle), skip the add, clear valid[d], and go to IDLE.
  - Set a sticky output collision_err (1 bit, reset 0) and add a counter output collision_cnt (16 bits, saturating).
- When not defined: no compare and no extra ports; equal x is forwarded to point_add unchanged.

Decomposition:
- Package msm_pkg holds:
  - COORD_W and WINDOW_BITS defaults;
  - typedef point_t (struct of x,y logic[COORD_W-1:0]);
  - typedef bucket_idx_t;
  - the FSM state enum.
- One sub-module, bucket_regfile: NB entries, 1 read port, 1 write port, and valid bits with per-entry clear. It is shared by accumulate and flush.

Test Plan:
1. Hold Reset=0 for 2 cycles, then set Reset=1 → in_ready=1, add_reset=1, out_valid=0, busy=0.
2. Input P=(6,1), digit=3 → no add_reset deassertion; 2 cycles later in_ready=1. Flush → bucket 3 reads (6,1), out_empty=0; all others read out_empty=1; out_last is set at index 15.
3. Input (6,1) then (8,1), both digit 3 → add_P=(6,1), add_Q=(8,1). The model drives add_Done after 5 cycles with R=(0xAA,0xBB) → bucket 3 becomes (0xAA,0xBB) on the next flush.
4. Input digit=0 with point (9,9) → ignored, in_ready high next cycle, no bucket changes.
5. Flush with out_ready stalled low for 4 cycles at index 2 → outputs stable. After resume, the drain completes and a second flush reads all buckets empty.
6. Reset=0 asserted during WAIT → returns to IDLE, add_reset=1, all buckets empty. With BUCKET_COLLISION_DETECT_EN: input (6,1) then (6,7) on digit 5 → no add is issued, collision_err=1, and bucket 5 reads empty.
